// File: rtl/mac_pkg.sv
// Shared widths and FSM state encoding for the Wallace MAC accumulator.
package mac_pkg;
    localparam int PROD_W = 8;
    localparam int ACC_W  = 16;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/sat_add.sv
// Saturating adder: accumulator plus zero-extended product, clamped to all-ones.
module sat_add #(
    parameter int ACC_W  = 16,
    parameter int PROD_W = 8
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] addend,
    output logic [ACC_W-1:0]  sum,
    output logic              sat
);
    logic [ACC_W:0] wide;

    // One extra bit catches the carry out, which is exactly the saturation case.
    always_comb begin
        wide = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, addend};
        sat  = wide[ACC_W];
        sum  = sat ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
    end
endmodule

// File: rtl/wallace_mac_accum.sv
// Sums a programmed number of multiplier products into a saturating accumulator
// with valid/ready handshakes on both the product input and the result output.
module wallace_mac_accum #(
    parameter int PROD_W = mac_pkg::PROD_W,
    parameter int ACC_W  = mac_pkg::ACC_W,
    parameter int CNT_W  = mac_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_terms,
    input  logic [PROD_W-1:0] prod,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow,
    output logic              busy
);
    import mac_pkg::*;

    state_t            state, state_next;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  terms_q;
    logic [ACC_W-1:0]  sum;
    logic              sat;
    logic              accept;
    logic              last_term;

    sat_add #(
        .ACC_W (ACC_W),
        .PROD_W(PROD_W)
    ) u_sat_add (
        .acc   (acc),
        .addend(prod),
        .sum   (sum),
        .sat   (sat)
    );

    assign in_ready  = (state == S_ACCUM);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign accept    = in_valid && in_ready;
    assign last_term = (cnt == (terms_q - CNT_W'(1)));

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = (num_terms == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (accept && last_term) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath registers; a start outside IDLE never reaches this case arm.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            acc      <= '0;
            cnt      <= '0;
            terms_q  <= '0;
            acc_out  <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        terms_q  <= num_terms;
                        acc      <= '0;
                        cnt      <= '0;
                        overflow <= 1'b0;
                        if (num_terms == '0) begin
                            acc_out <= '0;
                        end
                    end
                end
                S_ACCUM: begin
                    if (accept) begin
                        acc <= sum;
                        cnt <= cnt + CNT_W'(1);
                        if (sat) begin
                            overflow <= 1'b1;
                        end
                        if (last_term) begin
                            acc_out <= sum;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wallace_mac_accum.sv
// Directed bench for wallace_mac_accum: a 16-bit and a 10-bit accumulator share stimulus.
module tb_wallace_mac_accum;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  num_terms;
    logic [7:0]  prod;
    logic        in_valid;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_overflow, a_busy;
    logic [15:0] a_acc_out;
    logic        b_in_ready, b_out_valid, b_overflow, b_busy;
    logic [9:0]  b_acc_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int               n;
        logic [14:0][7:0] prods;
        int               exp_a;
        int               exp_a_ovf;
        int               exp_b;
        int               exp_b_ovf;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    wallace_mac_accum #(.PROD_W(8), .ACC_W(16), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .start(start), .num_terms(num_terms), .prod(prod),
        .in_valid(in_valid), .in_ready(a_in_ready), .acc_out(a_acc_out),
        .out_valid(a_out_valid), .out_ready(out_ready), .overflow(a_overflow), .busy(a_busy)
    );

    wallace_mac_accum #(.PROD_W(8), .ACC_W(10), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .start(start), .num_terms(num_terms), .prod(prod),
        .in_valid(in_valid), .in_ready(b_in_ready), .acc_out(b_acc_out),
        .out_valid(b_out_valid), .out_ready(out_ready), .overflow(b_overflow), .busy(b_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    function automatic vec_t make_vec(input int n, input int base, input int step,
                                      input int ea, input int eao, input int eb, input int ebo);
        vec_t v;
        v.n = n;
        for (int i = 0; i < 15; i++) begin
            v.prods[i] = 8'(base + i * step);
        end
        v.exp_a = ea; v.exp_a_ovf = eao; v.exp_b = eb; v.exp_b_ovf = ebo;
        return v;
    endfunction

    // Starts a job and feeds its products back to back; ends with both DUTs in DONE.
    task automatic apply_stimulus(input int n, input logic [14:0][7:0] prods);
        start = 1'b1;
        num_terms = 4'(n);
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            check("in_ready_accum", int'(a_in_ready), 1);
            check("out_valid_accum", int'(a_out_valid), 0);
            prod = prods[i];
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
        end
    endtask

    task automatic check_output(input int ea, input int eao, input int eb, input int ebo);
        check("a_out_valid", int'(a_out_valid), 1);
        check("a_acc_out", int'(a_acc_out), ea);
        check("a_overflow", int'(a_overflow), eao);
        check("b_out_valid", int'(b_out_valid), 1);
        check("b_acc_out", int'(b_acc_out), eb);
        check("b_overflow", int'(b_overflow), ebo);
        check("a_in_ready_done", int'(a_in_ready), 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("a_out_valid_drop", int'(a_out_valid), 0);
        check("a_busy_idle", int'(a_busy), 0);
        check("a_acc_out_kept", int'(a_acc_out), ea);
    endtask

    initial begin
        logic [14:0][7:0] p;

        vecs[0] = make_vec(3, 225, 0, 675, 0, 675, 0);
        vecs[1] = make_vec(1, 255, 0, 255, 0, 255, 0);
        vecs[2] = make_vec(4, 0, 0, 0, 0, 0, 0);
        vecs[3] = make_vec(4, 10, 20, 160, 0, 160, 0);
        vecs[4] = make_vec(15, 255, 0, 3825, 0, 1023, 1);
        vecs[5] = make_vec(5, 225, 0, 1125, 0, 1023, 1);
        vecs[6] = make_vec(0, 99, 0, 0, 0, 0, 0);
        vecs[7] = make_vec(6, 200, 10, 1350, 0, 1023, 1);

        rst = 1'b1; start = 1'b0; num_terms = '0; prod = '0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_acc_out", int'(a_acc_out), 0);
        check("rst_out_valid", int'(a_out_valid), 0);
        check("rst_busy", int'(a_busy), 0);
        check("rst_in_ready", int'(a_in_ready), 0);
        check("rst_overflow", int'(a_overflow), 0);

        for (int v = 0; v < 8; v++) begin
            apply_stimulus(vecs[v].n, vecs[v].prods);
            check_output(vecs[v].exp_a, vecs[v].exp_a_ovf, vecs[v].exp_b, vecs[v].exp_b_ovf);
        end

        // Overflow on the 10-bit unit must first appear on the fifth accept.
        start = 1'b1; num_terms = 4'd5; tick(); start = 1'b0;
        prod = 8'd225; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("b_ovf_before_5th", int'(b_overflow), 0);
        check("b_busy_accum", int'(b_busy), 1);
        tick();
        in_valid = 1'b0;
        check("b_ovf_at_5th", int'(b_overflow), 1);
        check_output(1125, 0, 1023, 1);

        // num_terms=0 goes straight to DONE without opening the input.
        start = 1'b1; num_terms = 4'd0; tick(); start = 1'b0;
        check("zero_in_ready", int'(a_in_ready), 0);
        check("zero_out_valid", int'(a_out_valid), 1);
        check_output(0, 0, 0, 0);

        // Bubbles between beats, then a stalled consumer.
        start = 1'b1; num_terms = 4'd2; tick(); start = 1'b0;
        prod = 8'd10; in_valid = 1'b1; tick(); in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bubble_busy", int'(a_busy), 1);
        end
        prod = 8'd20; in_valid = 1'b1; tick(); in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_out_valid", int'(a_out_valid), 1);
            check("stall_acc_out", int'(a_acc_out), 30);
            tick();
        end
        check_output(30, 0, 30, 0);

        // A start during ACCUM is ignored.
        start = 1'b1; num_terms = 4'd4; tick(); start = 1'b0;
        p = '0;
        for (int i = 0; i < 2; i++) begin
            prod = 8'd5; in_valid = 1'b1; tick();
        end
        in_valid = 1'b0; start = 1'b1; num_terms = 4'd1; tick(); start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("ign_start_not_done", int'(a_out_valid), 0);
            prod = 8'd5; in_valid = 1'b1; tick();
        end
        in_valid = 1'b0;
        check_output(20, 0, 20, 0);

        // Reset mid-job aborts, then a fresh job runs normally.
        start = 1'b1; num_terms = 4'd4; tick(); start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            prod = 8'd7; in_valid = 1'b1; tick();
        end
        in_valid = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
        check("abort_busy", int'(a_busy), 0);
        check("abort_out_valid", int'(a_out_valid), 0);
        check("abort_acc_out", int'(a_acc_out), 0);
        check("abort_in_ready", int'(a_in_ready), 0);
        for (int i = 0; i < 4; i++) p[i] = 8'd1;
        apply_stimulus(4, p);
        check_output(4, 0, 4, 0);

        // start together with out_ready in DONE is dropped.
        p[0] = 8'd3;
        apply_stimulus(1, p);
        check("s6_out_valid", int'(a_out_valid), 1);
        start = 1'b1; num_terms = 4'd2; out_ready = 1'b1; tick();
        start = 1'b0; out_ready = 1'b0;
        check("s6_busy", int'(a_busy), 0);
        check("s6_acc_out", int'(a_acc_out), 3);
        tick();
        check("s6_still_idle", int'(a_busy), 0);
        check("s6_in_ready", int'(a_in_ready), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
